// File: rtl/fast_score_dual.sv
`default_nettype none
// ============================================================================
// Module : fast_score_dual
// Desc   : FAST-9 segment test and corner score for two vertically adjacent
//          centres per beat; fixed 4-cycle, non-stalling pipeline.
//          Optional macro FAST_SCORE_STATS_EN adds a per-frame corner counter.
// Rev    : 1.0  initial release
// ============================================================================
module fast_score_dual #(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIXEL_WIDTH-1:0]     threshold,
  input  logic [56*PIXEL_WIDTH-1:0]  patch_in,
  input  logic                       patch_valid,
  input  logic [$clog2(COL_NUM)-1:0] x_in,
  input  logic [$clog2(ROW_NUM)-1:0] y_in,
  output logic                       score_vld,
  output logic [$clog2(COL_NUM)-1:0] x_out,
  output logic [$clog2(ROW_NUM)-1:0] y_out,
  output logic                       corner0,
  output logic                       corner1,
  output logic [PIXEL_WIDTH+3:0]     score0,
  output logic [PIXEL_WIDTH+3:0]     score1,
`ifdef FAST_SCORE_STATS_EN
  output logic [19:0]                corner_cnt,
`endif
  output logic                       score_eol
);
  localparam int c_pw = PIXEL_WIDTH;
  localparam int c_sw = PIXEL_WIDTH + 4;
  localparam int c_xw = $clog2(COL_NUM);
  localparam int c_yw = $clog2(ROW_NUM);

  typedef logic [c_pw-1:0] pix_t;
  typedef logic [c_sw-1:0] scr_t;

  // Flat patch offset (dr*7 + dc) of ring position i relative to the centre
  function automatic int ring_off(input int i);
    case (i)
      0: return -21;   1: return -20;   2: return -12;   3: return -4;
      4: return 3;     5: return 10;    6: return 16;    7: return 22;
      8: return 21;    9: return 20;    10: return 12;   11: return 4;
      12: return -3;   13: return -10;  14: return -16;  default: return -22;
    endcase
  endfunction

  function automatic logic has_run9(input logic [15:0] m);
    logic [31:0] d;
    logic        r;
    d = {m, m};
    r = 1'b0;
    for (int s = 0; s < 16; s++) begin
      if (&d[s +: 9]) r = 1'b1;
    end
    return r;
  endfunction

  pix_t w_ctr  [2];
  pix_t w_ring [2][16];

  generate
    for (genvar k = 0; k < 2; k++) begin : g_ctr
      localparam int c_ctr = 24 + 7 * k;
      assign w_ctr[k] = patch_in[c_ctr*c_pw +: c_pw];
      for (genvar i = 0; i < 16; i++) begin : g_ring
        localparam int c_idx = c_ctr + ring_off(i);
        assign w_ring[k][i] = patch_in[c_idx*c_pw +: c_pw];
      end
    end
  endgenerate

  // ---------------- Stage 1: capture centres, rings, threshold
  logic            r1_vld;
  pix_t            r1_c [2];
  pix_t            r1_p [2][16];
  pix_t            r1_t;
  logic [c_xw-1:0] r1_x;
  logic [c_yw-1:0] r1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_vld <= 1'b0;
      r1_t   <= '0;
      r1_x   <= '0;
      r1_y   <= '0;
      for (int k = 0; k < 2; k++) begin
        r1_c[k] <= '0;
        for (int i = 0; i < 16; i++) r1_p[k][i] <= '0;
      end
    end else begin
      r1_vld <= patch_valid;
      if (patch_valid) begin
        r1_t <= threshold;
        r1_x <= x_in;
        r1_y <= y_in;
        for (int k = 0; k < 2; k++) begin
          r1_c[k] <= w_ctr[k];
          for (int i = 0; i < 16; i++) r1_p[k][i] <= w_ring[k][i];
        end
      end
    end
  end

  // ---------------- Stage 2: saturating bounds, classification, differences
  logic [c_pw:0] w_sum    [2];
  pix_t          w_hi     [2];
  pix_t          w_lo     [2];
  logic [15:0]   w_bright [2];
  logic [15:0]   w_dark   [2];
  pix_t          w_db     [2][16];
  pix_t          w_dd     [2][16];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_sum[k] = {1'b0, r1_c[k]} + {1'b0, r1_t};
      w_hi[k]  = w_sum[k][c_pw] ? {c_pw{1'b1}} : w_sum[k][c_pw-1:0];
      w_lo[k]  = (r1_c[k] > r1_t) ? (r1_c[k] - r1_t) : '0;
      for (int i = 0; i < 16; i++) begin
        w_bright[k][i] = r1_p[k][i] > w_hi[k];
        w_dark[k][i]   = r1_p[k][i] < w_lo[k];
        // Only taken when the true difference is positive, so no wrap
        w_db[k][i] = w_bright[k][i] ? (r1_p[k][i] - r1_c[k] - r1_t) : '0;
        w_dd[k][i] = w_dark[k][i]   ? (r1_c[k] - r1_p[k][i] - r1_t) : '0;
      end
    end
  end

  logic            r2_vld;
  logic [15:0]     r2_bright [2];
  logic [15:0]     r2_dark   [2];
  pix_t            r2_db     [2][16];
  pix_t            r2_dd     [2][16];
  logic [c_xw-1:0] r2_x;
  logic [c_yw-1:0] r2_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_vld <= 1'b0;
      r2_x   <= '0;
      r2_y   <= '0;
      for (int k = 0; k < 2; k++) begin
        r2_bright[k] <= '0;
        r2_dark[k]   <= '0;
        for (int i = 0; i < 16; i++) begin
          r2_db[k][i] <= '0;
          r2_dd[k][i] <= '0;
        end
      end
    end else begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_x <= r1_x;
        r2_y <= r1_y;
        for (int k = 0; k < 2; k++) begin
          r2_bright[k] <= w_bright[k];
          r2_dark[k]   <= w_dark[k];
          for (int i = 0; i < 16; i++) begin
            r2_db[k][i] <= w_db[k][i];
            r2_dd[k][i] <= w_dd[k][i];
          end
        end
      end
    end
  end

  // ---------------- Stage 3: segment test and score sums
  logic w_corner [2];
  scr_t w_sb     [2];
  scr_t w_sd     [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_corner[k] = has_run9(r2_bright[k]) | has_run9(r2_dark[k]);
      w_sb[k] = '0;
      w_sd[k] = '0;
      for (int i = 0; i < 16; i++) begin
        w_sb[k] = w_sb[k] + scr_t'(r2_db[k][i]);
        w_sd[k] = w_sd[k] + scr_t'(r2_dd[k][i]);
      end
    end
  end

  logic            r3_vld;
  logic            r3_corner [2];
  scr_t            r3_sb     [2];
  scr_t            r3_sd     [2];
  logic [c_xw-1:0] r3_x;
  logic [c_yw-1:0] r3_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_vld <= 1'b0;
      r3_x   <= '0;
      r3_y   <= '0;
      for (int k = 0; k < 2; k++) begin
        r3_corner[k] <= 1'b0;
        r3_sb[k]     <= '0;
        r3_sd[k]     <= '0;
      end
    end else begin
      r3_vld <= r2_vld;
      if (r2_vld) begin
        r3_x <= r2_x;
        r3_y <= r2_y;
        for (int k = 0; k < 2; k++) begin
          r3_corner[k] <= w_corner[k];
          r3_sb[k]     <= w_sb[k];
          r3_sd[k]     <= w_sd[k];
        end
      end
    end
  end

  // ---------------- Stage 4: score select and output registers
  scr_t w_score [2];
  logic w_eol;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_score[k] = '0;
      if (r3_corner[k]) w_score[k] = (r3_sb[k] >= r3_sd[k]) ? r3_sb[k] : r3_sd[k];
    end
    w_eol = (r3_x == c_xw'(COL_NUM - 4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_vld <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      corner0   <= 1'b0;
      corner1   <= 1'b0;
      score0    <= '0;
      score1    <= '0;
      score_eol <= 1'b0;
    end else begin
      score_vld <= r3_vld;
      score_eol <= r3_vld & w_eol;
      if (r3_vld) begin
        x_out   <= r3_x;
        y_out   <= r3_y;
        corner0 <= r3_corner[0];
        corner1 <= r3_corner[1];
        score0  <= w_score[0];
        score1  <= w_score[1];
      end
    end
  end

`ifdef FAST_SCORE_STATS_EN
  // The first beat of a frame restarts the count with its own corners
  logic [19:0] w_cnt_base;
  logic [20:0] w_cnt_sum;

  always_comb begin
    w_cnt_base = ((r3_x == c_xw'(3)) && (r3_y == c_yw'(3))) ? 20'd0 : corner_cnt;
    w_cnt_sum  = {1'b0, w_cnt_base} + 21'(r3_corner[0]) + 21'(r3_corner[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corner_cnt <= '0;
    end else if (r3_vld) begin
      corner_cnt <= w_cnt_sum[20] ? 20'hFFFFF : w_cnt_sum[19:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fast_score_dual.sv
`default_nettype none
// ============================================================================
// Module : tb_fast_score_dual
// Desc   : Self-checking bench for fast_score_dual: directed table, stream,
//          reset flush and randomized beats against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fast_score_dual;
  localparam int COL_NUM = 640;
  localparam int ROW_NUM = 480;
  localparam int PW      = 8;
  localparam int NPIX    = 56;
  localparam int DR [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
  localparam int DC [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};

  typedef logic [NPIX*PW-1:0] patch_t;
  typedef struct { int due; int x; int y; bit c0; bit c1; int s0; int s1; bit eol; } exp_t;
  typedef struct { patch_t p; int t; bit c0; int s0; } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [PW-1:0] threshold = '0;
  patch_t       patch_in = '0;
  logic         patch_valid = 1'b0;
  logic [9:0]   x_in = '0;
  logic [8:0]   y_in = '0;
  logic         score_vld, corner0, corner1, score_eol;
  logic [9:0]   x_out;
  logic [8:0]   y_out;
  logic [11:0]  score0, score1;
`ifdef FAST_SCORE_STATS_EN
  logic [19:0]  corner_cnt;
`endif

  fast_score_dual #(.COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM), .PIXEL_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .threshold(threshold), .patch_in(patch_in),
    .patch_valid(patch_valid), .x_in(x_in), .y_in(y_in), .score_vld(score_vld),
    .x_out(x_out), .y_out(y_out), .corner0(corner0), .corner1(corner1),
    .score0(score0), .score1(score1),
`ifdef FAST_SCORE_STATS_EN
    .corner_cnt(corner_cnt),
`endif
    .score_eol(score_eol));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   cnt_m = 0;
  int   beat_no = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pix(input patch_t p, input int r, input int c);
    return int'(p[(r*7+c)*PW +: PW]);
  endfunction

  function automatic patch_t setp(input patch_t p, input int r, input int c, input int v);
    p[(r*7+c)*PW +: PW] = PW'(v);
    return p;
  endfunction

  function automatic patch_t flat(input int v);
    patch_t p;
    p = '0;
    for (int i = 0; i < NPIX; i++) p = setp(p, i / 7, i % 7, v);
    return p;
  endfunction

  // Reference: classify each ring pixel, find the longest circular run
  function automatic void model(input patch_t p, input int cr, input int t,
                                output bit corner, output int score);
    int c, v, hi, lo, sb, sd, rb, rd;
    int st [16];
    bit fb, fd;
    c  = pix(p, cr, 3);
    hi = (c + t > 255) ? 255 : c + t;
    lo = (c - t < 0) ? 0 : c - t;
    sb = 0; sd = 0;
    for (int i = 0; i < 16; i++) begin
      v = pix(p, cr + DR[i], 3 + DC[i]);
      st[i] = (v > hi) ? 1 : ((v < lo) ? -1 : 0);
      if (v > hi) sb += v - c - t;
      if (v < lo) sd += c - v - t;
    end
    rb = 0; rd = 0; fb = 0; fd = 0;
    for (int j = 0; j < 32; j++) begin
      rb = (st[j % 16] == 1)  ? rb + 1 : 0;
      rd = (st[j % 16] == -1) ? rd + 1 : 0;
      if (rb >= 9) fb = 1;
      if (rd >= 9) fd = 1;
    end
    corner = fb | fd;
    score  = corner ? ((sb >= sd) ? sb : sd) : 0;
  endfunction

  task automatic drive(input patch_t p, input int t, input int x, input int y,
                       input bit ovr, input bit oc0, input int os0);
    exp_t e;
    bit   c;
    int   s;
    @(posedge clk); #1;
    patch_in = p; threshold = PW'(t); x_in = 10'(x); y_in = 9'(y); patch_valid = 1'b1;
    e.due = cyc + 4; e.x = x; e.y = y;
    model(p, 3, t, c, s); e.c0 = c; e.s0 = s;
    if (ovr) begin e.c0 = oc0; e.s0 = os0; end
    model(p, 4, t, c, s); e.c1 = c; e.s1 = s;
    e.eol = (x == COL_NUM - 4);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      patch_valid = 1'b0;
    end
  endtask

  task automatic rand_patch(output patch_t p, output int t);
    int k, c, s, len, v;
    bit br;
    p = '0;
    for (int i = 0; i < NPIX; i++) p = setp(p, i / 7, i % 7, $urandom_range(0, 255));
    t = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
    k = $urandom_range(0, 1);
    c = $urandom_range(0, 255);
    p = setp(p, 3 + k, 3, c);
    s = $urandom_range(0, 15);
    len = $urandom_range(6, 14);
    br = $urandom_range(0, 1) == 1;
    for (int j = 0; j < len; j++) begin
      v = br ? c + t + $urandom_range(1, 60) : c - t - $urandom_range(1, 60);
      v = (v > 255) ? 255 : ((v < 0) ? 0 : v);
      p = setp(p, 3 + k + DR[(s + j) % 16], 3 + DC[(s + j) % 16], v);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        me = exp_q.pop_front();
        beat_no++;
        chk($sformatf("b%0d_vld", beat_no), int'(score_vld), 1);
        chk($sformatf("b%0d_x", beat_no), int'(x_out), me.x);
        chk($sformatf("b%0d_y", beat_no), int'(y_out), me.y);
        chk($sformatf("b%0d_corner0", beat_no), int'(corner0), int'(me.c0));
        chk($sformatf("b%0d_score0", beat_no), int'(score0), me.s0);
        chk($sformatf("b%0d_corner1", beat_no), int'(corner1), int'(me.c1));
        chk($sformatf("b%0d_score1", beat_no), int'(score1), me.s1);
        chk($sformatf("b%0d_eol", beat_no), int'(score_eol), int'(me.eol));
`ifdef FAST_SCORE_STATS_EN
        if (me.x == 3 && me.y == 3) cnt_m = 0;
        cnt_m = cnt_m + int'(me.c0) + int'(me.c1);
        if (cnt_m > 20'hFFFFF) cnt_m = 20'hFFFFF;
        chk($sformatf("b%0d_corner_cnt", beat_no), int'(corner_cnt), cnt_m);
`endif
      end else if (score_vld || score_eol) begin
        chk("unexpected_vld", int'(score_vld | score_eol), 0);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, int'(score_vld), 0);
    chk({tag, "_eol"}, int'(score_eol), 0);
    chk({tag, "_corners"}, int'({corner0, corner1}), 0);
    chk({tag, "_scores"}, int'(score0) + int'(score1), 0);
    chk({tag, "_xy"}, int'(x_out) + int'(y_out), 0);
`ifdef FAST_SCORE_STATS_EN
    chk({tag, "_cnt"}, int'(corner_cnt), 0);
`endif
  endtask

  vec_t   vt [8];
  patch_t p;
  int     t;

  initial begin
    // Directed vectors: upper-centre expectations are fixed constants
    vt[0].p = flat(100); vt[0].t = 20; vt[0].c0 = 0; vt[0].s0 = 0;
    p = flat(100);
    for (int i = 0; i <= 8; i++) p = setp(p, 3 + DR[i], 3 + DC[i], 150);
    vt[1].p = p; vt[1].t = 20; vt[1].c0 = 1; vt[1].s0 = 270;
    p = flat(100);
    for (int j = 0; j < 9; j++) p = setp(p, 3 + DR[(12 + j) % 16], 3 + DC[(12 + j) % 16], 50);
    vt[2].p = p; vt[2].t = 20; vt[2].c0 = 1; vt[2].s0 = 270;
    p = flat(100);
    for (int j = 0; j < 8; j++) p = setp(p, 3 + DR[(12 + j) % 16], 3 + DC[(12 + j) % 16], 50);
    vt[3].p = p; vt[3].t = 20; vt[3].c0 = 0; vt[3].s0 = 0;
    p = flat(250);
    for (int i = 0; i < 16; i++) p = setp(p, 3 + DR[i], 3 + DC[i], 255);
    vt[4].p = p; vt[4].t = 20; vt[4].c0 = 0; vt[4].s0 = 0;
    p = flat(10);
    for (int i = 0; i < 16; i++) p = setp(p, 3 + DR[i], 3 + DC[i], 0);
    vt[5].p = p; vt[5].t = 20; vt[5].c0 = 0; vt[5].s0 = 0;
    p = flat(100);
    for (int i = 0; i < 16; i++) p = setp(p, 3 + DR[i], 3 + DC[i], 200);
    vt[6].p = p; vt[6].t = 20; vt[6].c0 = 1; vt[6].s0 = 1280;
    p = flat(100);
    for (int i = 0; i <= 8; i++) p = setp(p, 3 + DR[i], 3 + DC[i], (i == 4) ? 100 : 150);
    vt[7].p = p; vt[7].t = 20; vt[7].c0 = 0; vt[7].s0 = 0;

    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    foreach (vt[i]) begin
      drive(vt[i].p, vt[i].t, 20 + i, 40, 1'b1, vt[i].c0, vt[i].s0);
      idle(1);
    end
    // t=0 edge: one step above the centre is already bright
    p = flat(100);
    for (int i = 0; i <= 8; i++) p = setp(p, 3 + DR[i], 3 + DC[i], 101);
    drive(p, 0, 30, 40, 1'b1, 1'b1, 9);
    idle(6);

    // Back-to-back row tail, eol only on the last centre
    for (int b = 0; b < 10; b++) begin
      rand_patch(p, t);
      drive(p, t, (b == 9) ? COL_NUM - 4 : 3 + b, 3, 1'b0, 1'b0, 0);
    end
    idle(6);

    // Reset with three beats in flight
    for (int b = 0; b < 3; b++) begin
      rand_patch(p, t);
      drive(p, t, 100 + b, 7, 1'b0, 1'b0, 0);
    end
    @(posedge clk); #1;
    patch_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    #1 chk_zero("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    idle(8);
    chk_zero("after_flush");

    // Randomized beats with random gaps and occasional frame starts
    for (int n = 0; n < 400; n++) begin
      rand_patch(p, t);
      drive(p, t,
            ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(3, COL_NUM - 4),
            ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, ROW_NUM - 2),
            1'b0, 1'b0, 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(10);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
